// File: rtl/xadc_drp_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xadc_drp_responder                                           |
// | Description : Behavioural stand-in for the XADC hard block. Answers DRP    |
// |               reads/writes with a fixed latency and runs a timed channel   |
// |               sequencer (BUSY/EOS) over digital 12-bit sample inputs.      |
// |               Optional sticky DRP_ERR output under XADC_DRP_ERR_EN.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module xadc_drp_responder #(
  parameter int READ_LATENCY = 4,   // DEN cycle to DRDY cycle, 1..15
  parameter int CONV_CYCLES  = 26,  // BUSY cycles per conversion, 2..255
  parameter int SEQ_GAP      = 4    // idle cycles between conversions, 1..255
) (
  input  logic        clk,
  input  logic        rst,
`ifdef XADC_DRP_ERR_EN
  output logic        DRP_ERR,
`endif
  input  logic [6:0]  DADDR,
  input  logic        DEN,
  input  logic        DWE,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  output logic        DRDY,
  output logic        BUSY,
  output logic        EOS,
  input  logic [11:0] SAMPLE_VPVN,
  input  logic [11:0] SAMPLE_AUX0,
  input  logic [11:0] SAMPLE_AUX1,
  input  logic [11:0] SAMPLE_AUX2,
  input  logic [11:0] SAMPLE_AUX3,
  input  logic [11:0] SAMPLE_AUX8
);

  localparam logic [3:0] C_LAT_LOAD  = 4'(READ_LATENCY - 1);
  localparam logic [7:0] C_CONV_LOAD = 8'(CONV_CYCLES - 1);
  localparam logic [7:0] C_GAP_LOAD  = 8'(SEQ_GAP - 1);
  localparam logic [2:0] C_LAST_CH   = 3'd5;

  typedef enum logic [0:0] {DRP_IDLE = 1'b0, DRP_WAIT = 1'b1} drp_state_t;
  typedef enum logic [1:0] {SEQ_GAP_ST = 2'd0, SEQ_CONV_ST = 2'd1, SEQ_LATCH_ST = 2'd2} seq_state_t;

  drp_state_t  drp_state_q, drp_state_d;
  logic [3:0]  drp_cnt_q, drp_cnt_d;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [15:0] di_q;
  logic [15:0] do_q;
  logic [15:0] res_q [0:5];   // VPVN, AUX0, AUX1, AUX2, AUX3, AUX8
  logic [15:0] cfg_q [0:2];   // 0x40, 0x41, 0x42

  seq_state_t  seq_state_q, seq_state_d;
  logic [7:0]  seq_cnt_q, seq_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        eos_q, eos_d;
  logic        w_latch;

  logic        w_drdy, w_accept, w_wr, w_do_load;
  logic [6:0]  w_rd_addr;
  logic        w_rd_we;
  logic [15:0] w_rd_data;
  logic [11:0] w_sample;

  // DRDY is the last counted cycle; a new DEN is accepted when idle or on DRDY
  assign w_drdy   = (drp_state_q == DRP_WAIT) && (drp_cnt_q == 4'd0);
  assign w_accept = DEN && ((drp_state_q == DRP_IDLE) || w_drdy);
  assign w_wr     = w_drdy && we_q;

  // DRP next-state and latency counter
  always_comb begin
    drp_state_d = drp_state_q;
    drp_cnt_d   = drp_cnt_q;
    if (w_accept) begin
      drp_state_d = DRP_WAIT;
      drp_cnt_d   = C_LAT_LOAD;
    end else if (drp_state_q == DRP_WAIT) begin
      if (drp_cnt_q == 4'd0) drp_state_d = DRP_IDLE;
      else                   drp_cnt_d   = drp_cnt_q - 4'd1;
    end
  end

  // DO is loaded on the edge that opens the DRDY cycle, so a sequencer latch
  // landing in the DRDY cycle itself is not seen by that read.
  assign w_rd_addr = w_accept ? DADDR : addr_q;
  assign w_rd_we   = w_accept ? DWE   : we_q;
  assign w_do_load = (drp_state_d == DRP_WAIT) && (drp_cnt_d == 4'd0) && !w_rd_we;

  // Register read decode; unmapped addresses read as zero
  always_comb begin
    w_rd_data = 16'h0000;
    case (w_rd_addr)
      7'h03:   w_rd_data = res_q[0];
      7'h10:   w_rd_data = res_q[1];
      7'h11:   w_rd_data = res_q[2];
      7'h12:   w_rd_data = res_q[3];
      7'h13:   w_rd_data = res_q[4];
      7'h18:   w_rd_data = res_q[5];
      7'h40:   w_rd_data = cfg_q[0];
      7'h41:   w_rd_data = cfg_q[1];
      7'h42:   w_rd_data = cfg_q[2];
      default: w_rd_data = 16'h0000;
    endcase
  end

  // DRP state, transaction capture and read data register
  always_ff @(posedge clk) begin
    if (rst) begin
      drp_state_q <= DRP_IDLE;
      drp_cnt_q   <= 4'd0;
      addr_q      <= 7'd0;
      we_q        <= 1'b0;
      di_q        <= 16'h0000;
      do_q        <= 16'h0000;
    end else begin
      drp_state_q <= drp_state_d;
      drp_cnt_q   <= drp_cnt_d;
      if (w_accept) begin
        addr_q <= DADDR;
        we_q   <= DWE;
        di_q   <= DI;
      end
      if (w_do_load) do_q <= w_rd_data;
    end
  end

  // Sequencer next-state: gap -> conversion -> latch, channel index advance
  always_comb begin
    seq_state_d = seq_state_q;
    seq_cnt_d   = seq_cnt_q;
    idx_d       = idx_q;
    eos_d       = 1'b0;
    w_latch     = 1'b0;
    case (seq_state_q)
      SEQ_GAP_ST: begin
        if (seq_cnt_q != 8'd0) begin
          seq_cnt_d = seq_cnt_q - 8'd1;
        end else if (!cfg_q[1][15]) begin
          seq_state_d = SEQ_CONV_ST;
          seq_cnt_d   = C_CONV_LOAD;
        end
      end
      SEQ_CONV_ST: begin
        if (seq_cnt_q != 8'd0) seq_cnt_d   = seq_cnt_q - 8'd1;
        else                   seq_state_d = SEQ_LATCH_ST;
      end
      SEQ_LATCH_ST: begin
        w_latch     = 1'b1;
        seq_state_d = SEQ_GAP_ST;
        seq_cnt_d   = C_GAP_LOAD;
        if (idx_q == C_LAST_CH) begin
          idx_d = 3'd0;
          eos_d = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: begin
        seq_state_d = SEQ_GAP_ST;
        seq_cnt_d   = C_GAP_LOAD;
      end
    endcase
  end

  // Current channel's sample input
  always_comb begin
    w_sample = 12'h000;
    case (idx_q)
      3'd0:    w_sample = SAMPLE_VPVN;
      3'd1:    w_sample = SAMPLE_AUX0;
      3'd2:    w_sample = SAMPLE_AUX1;
      3'd3:    w_sample = SAMPLE_AUX2;
      3'd4:    w_sample = SAMPLE_AUX3;
      3'd5:    w_sample = SAMPLE_AUX8;
      default: w_sample = 12'h000;
    endcase
  end

  // Sequencer state and EOS pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_state_q <= SEQ_GAP_ST;
      seq_cnt_q   <= C_GAP_LOAD;
      idx_q       <= 3'd0;
      eos_q       <= 1'b0;
    end else begin
      seq_state_q <= seq_state_d;
      seq_cnt_q   <= seq_cnt_d;
      idx_q       <= idx_d;
      eos_q       <= eos_d;
    end
  end

  // Result registers written by the sequencer, config registers by DRP writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) res_q[i] <= 16'h0000;
      for (int i = 0; i < 3; i++) cfg_q[i] <= 16'h0000;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (w_latch && (idx_q == 3'(i))) res_q[i] <= {w_sample, 4'b0000};
      end
      if (w_wr) begin
        case (addr_q)
          7'h40:   cfg_q[0] <= di_q;
          7'h41:   cfg_q[1] <= di_q;
          7'h42:   cfg_q[2] <= di_q;
          default: ;
        endcase
      end
    end
  end

`ifdef XADC_DRP_ERR_EN
  logic err_q;

  // Sticky flag for DEN arriving while a transaction is still counting
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (DEN && (drp_state_q == DRP_WAIT) && !w_drdy) begin
      err_q <= 1'b1;
    end else if (w_wr && (addr_q == 7'h42) && di_q[0]) begin
      err_q <= 1'b0;
    end
  end

  assign DRP_ERR = err_q;
`endif

  assign DO   = do_q;
  assign DRDY = w_drdy;
  assign BUSY = (seq_state_q == SEQ_CONV_ST);
  assign EOS  = eos_q;

endmodule
`default_nettype wire
